cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 2, SHALL set the number of cbus requesters (port 0 = ICache, port 1 = DCache).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 ireqs  input  cbus_req_t[NUM_INPUTS]  per-requester cbus requests (valid, is_write, size, addr, strobe, data, len).
REQ-005 iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester responses (ready, last, data).
REQ-006 oreq  output  cbus_req_t  request to the memory-side cbus.
REQ-007 oresp  input  cbus_resp_t  response from the memory-side cbus.

Function
REQ-008 The arbiter SHALL have two states, IDLE and BUSY, plus registers for the granted index (sel) and the round-robin pointer (rr).
REQ-009 In IDLE it SHALL grant the first i with ireqs[i].valid=1, searching from rr upward and wrapping modulo NUM_INPUTS. It SHALL load sel=i and enter BUSY on the next edge.
REQ-010 If no input is valid in IDLE, the arbiter SHALL stay in IDLE with sel and rr unchanged.
REQ-011 In IDLE, oreq SHALL be all-zero and every iresps[i] SHALL be all-zero. Grant latency is 1 cycle, and no request passes through combinationally in the grant cycle.
REQ-012 In BUSY, oreq SHALL equal ireqs[sel] bit-for-bit, with no field modification.
REQ-013 In BUSY, iresps[sel] SHALL equal oresp, and iresps[j] for j != sel SHALL be all-zero.
REQ-014 The grant SHALL be held for the whole transaction, for every beat of MLEN1/MLEN4/MLEN8/MLEN16 bursts, reads and writes alike.
REQ-015 In BUSY, when oresp.ready=1 and oresp.last=1 on an edge, the arbiter SHALL return to IDLE and set rr=(sel+1) mod NUM_INPUTS.
REQ-016 Back-to-back requests SHALL incur exactly one IDLE cycle between transactions.
REQ-017 When requests are simultaneous in IDLE, only one port SHALL be granted. Losers SHALL see ready=0 and are required to hold valid and all fields stable until granted.
REQ-018 A port issuing consecutive transactions SHALL NOT be granted twice in a row while another port is valid (round-robin fairness).
REQ-019 If ireqs[sel].valid drops during BUSY (a protocol violation), the arbiter SHALL still forward ireqs[sel] unchanged and remain BUSY until oresp.ready and oresp.last.
REQ-020 oresp.ready/last seen in IDLE SHALL be ignored; no state change and no response SHALL be routed to any port.
REQ-021 The arbiter SHALL contain a beat counter, width 4 bits, cleared on grant and incremented on each oresp.ready in BUSY. It SHALL be exported only to simulation (for assertions), not used for control.

Reset
REQ-022 Assertion of resetn=0 SHALL asynchronously force state=IDLE, sel=0, rr=0 and beat counter=0. oreq.valid=0 and all iresps.ready=0 SHALL follow immediately (combinationally from state).
REQ-023 Reset asserted mid-burst SHALL abort the transaction without any further beat being routed. After release, arbitration SHALL restart from rr=0.

Structure
REQ-024 cbus_req_t, cbus_resp_t, the MLEN*/MSIZE* constants and the arbiter state enum SHALL live in the shared common package; no local redefinition.
REQ-025 A sub-module rr_select (request vector + pointer -> one-hot/index grant + any-valid flag) SHALL hold the wrap-around priority search. The top SHALL hold the FSM and muxing.

Verification
REQ-026 Only port1 issues a read at 0x0000_1000 with MLEN4; memory returns 0xA0..0xA3 with ready each cycle -> oreq.valid rises 1 cycle after request; iresps[1] gets 4 beats, last on beat 4; iresps[0] stays all-zero; 1 IDLE cycle follows.
REQ-027 Both ports are valid in the same cycle from reset (rr=0) -> port0 is granted first; after its last beat, port1 is granted with rr=1. Port1's held request arrives at oreq unchanged.
REQ-028 Port1 issues 3 back-to-back MLEN1 writes (strobe 4'b1111, data 0xDEADBEEF) while port0 is continuously valid -> grant order is 1,0,1,0,1, never 1,1.
REQ-029 Memory inserts ready=0 stalls on beats 2 and 3 of an MLEN4 burst -> grant is held, oreq is stable through the stalls, and the burst completes with exactly 4 ready beats.
REQ-030 resetn is pulsed low at beat 2 of a port0 MLEN4 read -> oreq.valid and iresps[0].ready are 0 within the same cycle; after release, state=IDLE and rr=0, and port0 is re-granted if still valid.
REQ-031 Assertions SHALL check that no two iresps[i].ready are high at once and that oreq.valid=0 whenever state=IDLE.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types and constants for the cbus requester arbiter.
// Holds the request/response structs, burst length and size codes, and arbiter states.
package cbus_arbiter_pkg;

   typedef logic [1:0] mlen_t;
   localparam mlen_t MLEN1  = 2'd0;
   localparam mlen_t MLEN4  = 2'd1;
   localparam mlen_t MLEN8  = 2'd2;
   localparam mlen_t MLEN16 = 2'd3;

   typedef logic [2:0] msize_t;
   localparam msize_t MSIZE1 = 3'd0;
   localparam msize_t MSIZE2 = 3'd1;
   localparam msize_t MSIZE4 = 3'd2;
   localparam msize_t MSIZE8 = 3'd3;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      msize_t      size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      mlen_t       len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef logic [0:0] arb_state_t;
   localparam arb_state_t ARB_IDLE = 1'b0;
   localparam arb_state_t ARB_BUSY = 1'b1;

   function automatic logic [4:0] mlen_beats(input mlen_t len);
      case (len)
         MLEN1:   return 5'd1;
         MLEN4:   return 5'd4;
         MLEN8:   return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Round-robin priority search: first set request at or above ptr, wrapping modulo N.
module cbus_arbiter_rr_select #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < int'(N); k++) begin
         // ptr and k are both below N, so a single subtraction wraps the sum
         sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
         end
         cand = sum[IDX_W-1:0];
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Arbitrates NUM_INPUTS cbus requesters onto one memory-side cbus, holding the grant
// for a whole burst and rotating priority after each completed transaction.
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  ireqs  [NUM_INPUTS],
   output cbus_resp_t iresps [NUM_INPUTS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       sel_q, sel_d;
   logic [IDX_W-1:0]       rr_q, rr_d;
   logic [3:0]             beat_q, beat_d;
   logic [IDX_W-1:0]       grant_idx;
   logic [NUM_INPUTS-1:0]  grant_oh;
   logic [NUM_INPUTS-1:0]  valid_vec;
   logic [NUM_INPUTS-1:0]  ready_vec;
   logic                   any_valid;

   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         valid_vec[i] = ireqs[i].valid;
      end
   end

   cbus_arbiter_rr_select #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .req   (valid_vec),
      .ptr   (rr_q),
      .grant (grant_oh),
      .idx   (grant_idx),
      .any   (any_valid)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_valid) begin
               state_d = ARB_BUSY;
               sel_d   = grant_idx;
               beat_d  = '0;
            end
         end
         default: begin
            if (oresp.ready) begin
               beat_d = beat_q + 4'd1;
            end
            if (oresp.ready && oresp.last) begin
               state_d = ARB_IDLE;
               rr_d    = (sel_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_q + IDX_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         beat_q  <= beat_d;
      end
   end

   // Outputs decode from registered state only, so reset silences them at once
   always_comb begin
      oreq = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         iresps[i] = '0;
      end
      if (state_q == ARB_BUSY) begin
         oreq          = ireqs[sel_q];
         iresps[sel_q] = oresp;
      end
      ready_vec = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         ready_vec[i] = iresps[i].ready;
      end
   end

   a_single_ready: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(ready_vec));

   a_idle_no_req: assert property (@(posedge clk) disable iff (!resetn)
      (state_q == ARB_IDLE) |-> !oreq.valid);

   a_single_grant: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(grant_oh));

   a_burst_length: assert property (@(posedge clk) disable iff (!resetn)
      (state_q == ARB_BUSY && oresp.ready && oresp.last)
      |-> (({1'b0, beat_q} + 5'd1) == mlen_beats(oreq.len)));

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: single requester, contention, fairness, stalls,
// protocol violation and mid-burst reset.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   localparam int unsigned NUM = 2;

   logic       clk    = 1'b0;
   logic       resetn = 1'b0;
   cbus_req_t  ireqs  [NUM];
   cbus_resp_t iresps [NUM];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cbus_arbiter #(
      .NUM_INPUTS (NUM)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [3:0] strb,
                                        input mlen_t len);
      cbus_req_t r;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = MSIZE4;
      r.addr     = addr;
      r.strobe   = strb;
      r.data     = data;
      r.len      = len;
      return r;
   endfunction

   task automatic idle_zero(input string tag);
      check_eq({tag, "_state"}, 128'(dut.state_q), 128'(ARB_IDLE));
      check_eq({tag, "_oreq"}, 128'(oreq), 128'(0));
      check_eq({tag, "_resp0"}, 128'(iresps[0]), 128'(0));
      check_eq({tag, "_resp1"}, 128'(iresps[1]), 128'(0));
   endtask

   // Memory model for one granted burst; stall_mask bit g inserts one ready=0 cycle before beat g
   task automatic serve(input string tag, input int port, input int beats,
                        input logic [7:0] stall_mask, input logic [31:0] data0);
      int   got     = 0;
      int   seen    = 0;
      int   cyc     = 0;
      logic stalled = 1'b0;
      logic stall;
      while (got < beats && cyc < 64) begin
         stall       = stall_mask[got[2:0]] && !stalled;
         oresp.ready = !stall;
         oresp.last  = !stall && (got == beats - 1);
         oresp.data  = data0 + 32'(got);
         settle();
         check_eq({tag, "_busy"}, 128'(dut.state_q), 128'(ARB_BUSY));
         check_eq({tag, "_sel"}, 128'(dut.sel_q), 128'(port));
         check_eq({tag, "_oreq"}, 128'(oreq), 128'(ireqs[port]));
         check_eq({tag, "_resp"}, 128'(iresps[port]), 128'(oresp));
         check_eq({tag, "_other"}, 128'(iresps[1-port]), 128'(0));
         check_eq({tag, "_beatcnt"}, 128'(dut.beat_q), 128'(got));
         if (iresps[port].ready) seen++;
         tick();
         if (stall) begin
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
            got++;
         end
         cyc++;
      end
      oresp = '0;
      check_eq({tag, "_nbeats"}, 128'(seen), 128'(beats));
   endtask

   initial begin
      int order [5] = '{1, 0, 1, 0, 1};
      for (int i = 0; i < int'(NUM); i++) ireqs[i] = '0;
      oresp = '0;

      // Reset state
      #12;
      idle_zero("rst");
      check_eq("rst_sel", 128'(dut.sel_q), 128'(0));
      check_eq("rst_rr", 128'(dut.rr_q), 128'(0));
      check_eq("rst_beat", 128'(dut.beat_q), 128'(0));
      resetn = 1'b1;
      tick();

      // Single port1 MLEN4 read
      ireqs[1] = mk_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, MLEN4);
      settle();
      idle_zero("t1_grantcyc");
      tick();
      serve("t1", 1, 4, 8'h00, 32'hA0);
      ireqs[1] = '0;
      settle();
      idle_zero("t1_after");
      check_eq("t1_rr", 128'(dut.rr_q), 128'(0));
      // Stray memory response in IDLE is ignored
      oresp = '{ready: 1'b1, last: 1'b1, data: 32'h5555_5555};
      settle();
      idle_zero("t1_stray");
      tick();
      check_eq("t1_stray_state", 128'(dut.state_q), 128'(ARB_IDLE));
      check_eq("t1_stray_rr", 128'(dut.rr_q), 128'(0));
      oresp = '0;

      // Simultaneous requests from reset: port0 first, then port1 with held request
      resetn = 1'b0;
      settle();
      resetn = 1'b1;
      ireqs[0] = mk_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, MLEN1);
      ireqs[1] = mk_req(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, MLEN4);
      settle();
      idle_zero("t2_grantcyc");
      tick();
      serve("t2a", 0, 1, 8'h00, 32'hB0);
      ireqs[0] = '0;
      settle();
      idle_zero("t2_gap");
      check_eq("t2_rr", 128'(dut.rr_q), 128'(1));
      tick();
      check_eq("t2_held", 128'(oreq),
               128'(mk_req(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, MLEN4)));
      serve("t2b", 1, 4, 8'h00, 32'hC0);
      ireqs[1] = '0;

      // Fairness: port1 issues 3 MLEN1 writes while port0 stays valid
      for (int t = 0; t < 5; t++) begin
         if (t == 0) ireqs[1] = mk_req(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF, MLEN1);
         settle();
         idle_zero("t3_gap");
         tick();
         if (t == 0) ireqs[0] = mk_req(1'b0, 32'h0000_5000, 32'h0, 4'h0, MLEN1);
         serve("t3", order[t], 1, 8'h00, 32'hD0 + 32'(t));
      end
      ireqs[0] = '0;
      ireqs[1] = '0;
      settle();
      idle_zero("t3_end");

      // Valid dropped mid-burst: still forwarded, still BUSY until last
      ireqs[1] = mk_req(1'b0, 32'h0000_7000, 32'h0, 4'h0, MLEN4);
      settle();
      tick();
      ireqs[1].valid = 1'b0;
      serve("t6", 1, 4, 8'h00, 32'hE0);
      ireqs[1] = '0;
      settle();
      idle_zero("t6_end");
      check_eq("t6_rr", 128'(dut.rr_q), 128'(0));

      // Stalls before beats 2 and 3 of a port0 MLEN4 read
      ireqs[0] = mk_req(1'b0, 32'h0000_8000, 32'h0, 4'h0, MLEN4);
      settle();
      tick();
      serve("t4", 0, 4, 8'h06, 32'h90);
      ireqs[0] = '0;
      settle();
      idle_zero("t4_end");
      check_eq("t4_rr", 128'(dut.rr_q), 128'(1));

      // Reset pulsed at beat 2 of a port0 MLEN4 read
      ireqs[0] = mk_req(1'b0, 32'h0000_6000, 32'h0, 4'h0, MLEN4);
      settle();
      tick();
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'hF0};
      settle();
      check_eq("t5_beat1", 128'(iresps[0]), 128'(oresp));
      tick();
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'hF1};
      resetn = 1'b0;
      settle();
      check_eq("t5_rst_valid", 128'(oreq.valid), 128'(0));
      check_eq("t5_rst_ready", 128'(iresps[0].ready), 128'(0));
      check_eq("t5_rst_state", 128'(dut.state_q), 128'(ARB_IDLE));
      check_eq("t5_rst_rr", 128'(dut.rr_q), 128'(0));
      check_eq("t5_rst_beat", 128'(dut.beat_q), 128'(0));
      resetn = 1'b1;
      oresp  = '0;
      settle();
      idle_zero("t5_release");
      tick();
      serve("t5", 0, 4, 8'h00, 32'hF8);
      ireqs[0] = '0;
      settle();
      idle_zero("t5_end");
      check_eq("t5_rr", 128'(dut.rr_q), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
